event_recorder: RTL and testbench



---
 rtl/event_recorder_pkg.sv | 17 +
 rtl/event_fifo.sv | 53 +++++
 rtl/event_recorder.sv | 102 ++++++++++
 tb/tb_event_recorder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/event_recorder_pkg.sv
// event_recorder_pkg: shared defaults and record-width helper for the event recorder.
// EVENT_RECORDER_TIMESTAMP_EN adds the timestamp field to each record.
package event_recorder_pkg;
  localparam int NCH_DEF = 2;
  localparam int TOT_W_DEF = 16;
  localparam int TS_W_DEF = 32;
  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 256;
`ifdef EVENT_RECORDER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  function automatic int rec_w(input int nch, input int tot_w, input int ts_w);
    return (TS_EN ? ts_w : 0) + nch + 2 * tot_w;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: record store with registered read; pushes into a full FIFO are refused.
module event_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rv_q, rv_d, do_wr, do_rd;
  logic [W-1:0] rdata_q, rdata_d;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    do_wr = wr_en && !full && !clr;
    do_rd = rd_en && cnt_q != '0 && !clr;
    wptr_d = clr ? '0 : wptr_q + AW'(do_wr);
    rptr_d = clr ? '0 : rptr_q + AW'(do_rd);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rv_d = do_rd;
    rdata_d = do_rd ? mem[rptr_q] : rdata_q;
  end
  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk)
    if (do_wr) mem[wptr_q] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      rv_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      rv_q <= rv_d;
      rdata_q <= rdata_d;
    end
  assign count = cnt_q;
  assign rd_valid = rv_q;
  assign rd_data = rdata_q;
endmodule

// File: rtl/event_recorder.sv
// event_recorder: edge-counted trigger/singles metrics plus a FIFO of trigger records.
// EVENT_RECORDER_TIMESTAMP_EN prepends a free-running timestamp to each record.
module event_recorder import event_recorder_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int TOT_W = TOT_W_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic [NCH-1:0]                    SIGNAL,
  input  logic                              TRIGGER,
  input  logic                              LIVE_ACQUISITION,
  input  logic [TOT_W-1:0]                  TOT_SHORT,
  input  logic [TOT_W-1:0]                  TOT_LONG,
  input  logic                              READ_MODE,
  input  logic                              CLEAR,
  input  logic                              RD_REQ,
  output logic                              RD_VALID,
  output logic [rec_w(NCH,TOT_W,TS_W)-1:0]  RD_DATA,
  output logic [$clog2(DEPTH):0]            FIFO_COUNT,
  output logic                              OVERFLOW,
  output logic [CNT_W-1:0]                  NTRIGGERS,
  output logic [CNT_W-1:0]                  NDROPPED,
  output logic [CNT_W-1:0]                  LIVE_TIME,
  output logic [CNT_W-1:0]                  DEAD_TIME,
  output logic [NCH*CNT_W-1:0]              NSINGLES
);
  localparam int REC_W = rec_w(NCH, TOT_W, TS_W);
  logic [NCH-1:0] sig_q, sig_edge;
  logic trig_q, trig_edge, run, full, ovf_q, ovf_d;
  logic [CNT_W-1:0] ntrig_q, ntrig_d, ndrop_q, ndrop_d, live_q, live_d, dead_q, dead_d;
  logic [CNT_W-1:0] sing_q [NCH];
  logic [CNT_W-1:0] sing_d [NCH];
  logic [REC_W-1:0] rec;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
    return (en && ~&c) ? c + CNT_W'(1) : c;
  endfunction
`ifdef EVENT_RECORDER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;
  assign ts_d = CLEAR ? '0 : ts_q + TS_W'(1);
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) ts_q <= '0;
    else ts_q <= ts_d;
  assign rec = {ts_q, SIGNAL, TOT_SHORT, TOT_LONG};
`else
  assign rec = {SIGNAL, TOT_SHORT, TOT_LONG};
`endif
  always_comb begin
    run = !READ_MODE;
    sig_edge = SIGNAL & ~sig_q;
    trig_edge = TRIGGER && !trig_q;
    ntrig_d = CLEAR ? '0 : bump(ntrig_q, run && trig_edge);
    ndrop_d = CLEAR ? '0 : bump(ndrop_q, run && trig_edge && full);
    live_d = CLEAR ? '0 : bump(live_q, run && LIVE_ACQUISITION);
    dead_d = CLEAR ? '0 : bump(dead_q, run && !LIVE_ACQUISITION);
    ovf_d = !CLEAR && (ovf_q || (run && trig_edge && full));
    for (int k = 0; k < NCH; k++) sing_d[k] = CLEAR ? '0 : bump(sing_q[k], run && sig_edge[k]);
  end
  // Edge registers keep sampling through READ_MODE and CLEAR.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      sig_q <= '0;
      trig_q <= 1'b0;
      ntrig_q <= '0;
      ndrop_q <= '0;
      live_q <= '0;
      dead_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NCH; k++) sing_q[k] <= '0;
    end else begin
      sig_q <= SIGNAL;
      trig_q <= TRIGGER;
      ntrig_q <= ntrig_d;
      ndrop_q <= ndrop_d;
      live_q <= live_d;
      dead_q <= dead_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NCH; k++) sing_q[k] <= sing_d[k];
    end
  event_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(RESET_N),
    .clr(CLEAR),
    .wr_en(run && trig_edge),
    .wr_data(rec),
    .rd_en(RD_REQ),
    .rd_valid(RD_VALID),
    .rd_data(RD_DATA),
    .count(FIFO_COUNT),
    .full(full)
  );
  for (genvar k = 0; k < NCH; k++) begin : g_sing
    assign NSINGLES[k*CNT_W +: CNT_W] = sing_q[k];
  end
  assign NTRIGGERS = ntrig_q;
  assign NDROPPED = ndrop_q;
  assign LIVE_TIME = live_q;
  assign DEAD_TIME = dead_q;
  assign OVERFLOW = ovf_q;
endmodule

// File: tb/tb_event_recorder.sv
// tb_event_recorder: directed scenarios plus random traffic against a queue-based model.
module tb_event_recorder;
  localparam int NCH = 2, TOT_W = 16, TS_W = 32, CNT_W = 4, DEPTH = 4;
`ifdef EVENT_RECORDER_TIMESTAMP_EN
  localparam int REC_W = TS_W + NCH + 2 * TOT_W;
`else
  localparam int REC_W = NCH + 2 * TOT_W;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n, trigger, live, read_mode, clear, rd_req, rd_valid, overflow;
  logic [NCH-1:0] signal;
  logic [TOT_W-1:0] tot_short, tot_long;
  logic [REC_W-1:0] rd_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] ntriggers, ndropped, live_time, dead_time;
  logic [NCH*CNT_W-1:0] nsingles;
  int n_checks = 0, n_fail = 0;
  int m_ntrig, m_ndrop, m_live, m_dead;
  int m_sing [NCH];
  bit m_ovf, m_rv, m_ptrig;
  logic [NCH-1:0] m_psig;
  logic [TS_W-1:0] m_ts;
  logic [REC_W-1:0] m_rd;
  logic [REC_W-1:0] m_q [$];
  logic [TS_W-1:0] prev_ts;

  event_recorder #(.NCH(NCH), .TOT_W(TOT_W), .TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET_N(rst_n), .SIGNAL(signal), .TRIGGER(trigger), .LIVE_ACQUISITION(live),
    .TOT_SHORT(tot_short), .TOT_LONG(tot_long), .READ_MODE(read_mode), .CLEAR(clear),
    .RD_REQ(rd_req), .RD_VALID(rd_valid), .RD_DATA(rd_data), .FIFO_COUNT(fifo_count),
    .OVERFLOW(overflow), .NTRIGGERS(ntriggers), .NDROPPED(ndropped), .LIVE_TIME(live_time),
    .DEAD_TIME(dead_time), .NSINGLES(nsingles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v > CMAX ? CMAX : v;
  endfunction

  function automatic logic [REC_W-1:0] make_rec();
`ifdef EVENT_RECORDER_TIMESTAMP_EN
    return {m_ts, signal, tot_short, tot_long};
`else
    return {signal, tot_short, tot_long};
`endif
  endfunction

  task automatic model_reset();
    m_ntrig = 0; m_ndrop = 0; m_live = 0; m_dead = 0;
    foreach (m_sing[k]) m_sing[k] = 0;
    m_ovf = 0; m_rv = 0; m_ptrig = 0; m_psig = '0; m_ts = '0; m_rd = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit te, full;
    logic [NCH-1:0] se;
    te = trigger && !m_ptrig;
    se = signal & ~m_psig;
    full = m_q.size() == DEPTH;
    if (clear) begin
      m_ntrig = 0; m_ndrop = 0; m_live = 0; m_dead = 0;
      foreach (m_sing[k]) m_sing[k] = 0;
      m_ovf = 0; m_rv = 0; m_ts = '0;
      m_q.delete();
    end else begin
      m_rv = 0;
      if (rd_req && m_q.size() != 0) begin
        m_rv = 1;
        m_rd = m_q.pop_front();
      end
      if (!read_mode) begin
        if (te && full) begin
          m_ndrop = sat(m_ndrop + 1);
          m_ovf = 1;
        end else if (te) m_q.push_back(make_rec());
        m_ntrig = sat(m_ntrig + int'(te));
        foreach (m_sing[k]) m_sing[k] = sat(m_sing[k] + int'(se[k]));
        if (live) m_live = sat(m_live + 1);
        else m_dead = sat(m_dead + 1);
      end
      m_ts = m_ts + 1;
    end
    m_psig = signal;
    m_ptrig = trigger;
  endtask

  task automatic compare_all();
    check("ntriggers", 128'(ntriggers), 128'(m_ntrig));
    check("ndropped", 128'(ndropped), 128'(m_ndrop));
    check("live_time", 128'(live_time), 128'(m_live));
    check("dead_time", 128'(dead_time), 128'(m_dead));
    for (int k = 0; k < NCH; k++) check("nsingles", 128'(nsingles[k*CNT_W +: CNT_W]), 128'(m_sing[k]));
    check("overflow", 128'(overflow), 128'(m_ovf));
    check("fifo_count", 128'(fifo_count), 128'(m_q.size()));
    check("rd_valid", 128'(rd_valid), 128'(m_rv));
    if (m_rv) check("rd_data", 128'(rd_data), 128'(m_rd));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse();
    trigger = 1'b1; tick();
    trigger = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1; tick();
    rd_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ntrig"}, 128'(ntriggers), 0);
    check({tag, "_ndrop"}, 128'(ndropped), 0);
    check({tag, "_live"}, 128'(live_time), 0);
    check({tag, "_dead"}, 128'(dead_time), 0);
    check({tag, "_sing"}, 128'(nsingles), 0);
    check({tag, "_ovf"}, 128'(overflow), 0);
    check({tag, "_count"}, 128'(fifo_count), 0);
    check({tag, "_rv"}, 128'(rd_valid), 0);
    check({tag, "_rdata"}, 128'(rd_data), 0);
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; live = 1'b0; read_mode = 1'b0; clear = 1'b0; rd_req = 1'b0;
    signal = '0; tot_short = '0; tot_long = '0;
    model_reset();
    #3 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tot_short = 16'h0010; tot_long = 16'h0100;
    repeat (3) pulse();
    check("req042_ntrig", 128'(ntriggers), 3);
    check("req042_count", 128'(fifo_count), 3);
    prev_ts = '0;
    for (int i = 0; i < 3; i++) begin
      pop();
      check("req042_tot", 128'(rd_data[2*TOT_W-1:0]), 128'(32'h0010_0100));
`ifdef EVENT_RECORDER_TIMESTAMP_EN
      if (i > 0) check("req042_ts_inc", 128'(rd_data[REC_W-1 -: TS_W] > prev_ts), 1);
      prev_ts = rd_data[REC_W-1 -: TS_W];
`endif
    end
    do_clear();
    for (int i = 0; i < 6; i++) begin
      tot_long = 16'(i + 1);
      pulse();
    end
    check("req043_count", 128'(fifo_count), 4);
    check("req043_ndrop", 128'(ndropped), 2);
    check("req043_ovf", 128'(overflow), 1);
    pop();
    check("req043_first", 128'(rd_data[TOT_W-1:0]), 1);
    do_clear();
    signal = 2'b11; tick();
    signal = 2'b00; tick();
    repeat (2) begin
      signal = 2'b01; tick();
      signal = 2'b00; tick();
    end
    check("req044_s0", 128'(nsingles[CNT_W-1:0]), 3);
    check("req044_s1", 128'(nsingles[2*CNT_W-1:CNT_W]), 1);
    live = 1'b1;
    do_clear();
    repeat (20) tick();
    check("req045_live", 128'(live_time), 15);
    check("req045_dead", 128'(dead_time), 0);
    read_mode = 1'b1;
    repeat (5) pulse();
    do_clear();
    read_mode = 1'b0;
    check("req046_count", 128'(fifo_count), 0);
    check("req046_ntrig", 128'(ntriggers), 0);
    pop();
    check("req046_rv", 128'(rd_valid), 0);
    repeat (2) pulse();
    check("req047_pre", 128'(fifo_count), 2);
    trigger = 1'b1; signal = 2'b11;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("rst_edge_once", 128'(ntriggers), 1);
    trigger = 1'b0; signal = '0;
    for (int i = 0; i < 500; i++) begin
      trigger = ($urandom % 3) == 0;
      signal = NCH'($urandom);
      live = $urandom % 2;
      read_mode = ($urandom % 7) == 0;
      clear = ($urandom % 40) == 0;
      rd_req = ($urandom % 5) < 2;
      tot_short = TOT_W'($urandom);
      tot_long = TOT_W'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
